// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, display enable, frame/vblank/prefetch
// strobes, line-compare and vblank interrupts, and a completed-frame counter.
module video_timing_gen #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 80,
    parameter int V_BLANK     = 80,
    parameter int PREFETCH    = 8,
    parameter int FRAME_CNT_W = 16,
    localparam int H_TOTAL    = H_ACTIVE + H_BLANK,
    localparam int V_TOTAL    = V_ACTIVE + V_BLANK,
    localparam int HC_W       = $clog2(H_TOTAL),
    localparam int VC_W       = $clog2(V_TOTAL)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [VC_W-1:0]        lyc,
    input  logic                   irq_ack,
    output logic [HC_W-1:0]        x,
    output logic [VC_W-1:0]        y,
    output logic                   de,
    output logic                   frame_start,
    output logic                   vblank_start,
    output logic                   line_fetch,
    output logic [VC_W-1:0]        fetch_y,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   vblank_irq,
    output logic                   line_irq
);

    generate
        if (PREFETCH < 1 || PREFETCH > H_BLANK) begin : g_bad_prefetch
            $error("video_timing_gen: PREFETCH must lie in 1..H_BLANK");
        end
    endgenerate

    localparam logic [HC_W-1:0] X_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] X_FETCH = HC_W'(H_TOTAL - PREFETCH);
    localparam logic [VC_W-1:0] Y_LAST  = VC_W'(V_TOTAL - 1);

    logic [HC_W-1:0]        x_reg, x_next;
    logic [VC_W-1:0]        y_reg, y_next;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic                   vblank_irq_reg, vblank_irq_next;
    logic                   line_irq_reg, line_irq_next;
    logic [VC_W-1:0]        next_y;
    logic                   run;
    logic                   line_match;

    // Decoded outputs are also held low while reset is asserted, even with en=1.
    assign run = en & rst_n;

    always_comb begin
        x_next         = x_reg;
        y_next         = y_reg;
        frame_cnt_next = frame_cnt_reg;
        if (en) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                if (y_reg == Y_LAST) begin
                    y_next         = '0;
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                end else begin
                    y_next = y_reg + 1'b1;
                end
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    // Line that follows the current one; the last vblank line is followed by line 0.
    assign next_y = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;

    always_comb begin
        de           = run && (int'(x_reg) < H_ACTIVE) && (int'(y_reg) < V_ACTIVE);
        frame_start  = run && (x_reg == '0) && (y_reg == '0);
        vblank_start = run && (x_reg == '0) && (int'(y_reg) == V_ACTIVE);
        line_fetch   = run && (x_reg == X_FETCH) && (int'(next_y) < V_ACTIVE);
        fetch_y      = line_fetch ? next_y : '0;
        line_match   = run && (x_reg == '0) && (y_reg == lyc);
    end

    // A set condition overrides a simultaneous acknowledge.
    always_comb begin
        vblank_irq_next = vblank_start | (vblank_irq_reg & ~irq_ack);
        line_irq_next   = line_match | (line_irq_reg & ~irq_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg          <= '0;
            y_reg          <= '0;
            frame_cnt_reg  <= '0;
            vblank_irq_reg <= 1'b0;
            line_irq_reg   <= 1'b0;
        end else begin
            x_reg          <= x_next;
            y_reg          <= y_next;
            frame_cnt_reg  <= frame_cnt_next;
            vblank_irq_reg <= vblank_irq_next;
            line_irq_reg   <= line_irq_next;
        end
    end

    assign x          = x_reg;
    assign y          = y_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign vblank_irq = vblank_irq_reg;
    assign line_irq   = line_irq_reg;

endmodule
